uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_BITS, default 8, meaning number of data bits per frame (5..8).
REQ-002 Parameter PARITY_EN, default 0, meaning 1 = parity bit present after the data bits.
REQ-003 Parameter PARITY_ODD, default 0, meaning 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
REQ-004 sys_clk  in  1  single clock, positive-edge triggered.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 sample_clk  in  1  one-sys_clk-wide enable pulse at 16x baud; sys_clk is the only clock.
REQ-007 rx  in  1  asynchronous serial line, idle high.
REQ-008 rx_data  out  DATA_BITS  last received word, LSB first on the line.
REQ-009 rx_valid  out  1  one-cycle pulse when a good frame completes.
REQ-010 frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
REQ-011 parity_err  out  1  one-cycle pulse, coincident with rx_valid, on parity mismatch.

Function
REQ-012 rx shall pass through a 2-FF synchronizer with reset value 1 (rx_s); all decisions use rx_s.
REQ-013 FSM states shall be IDLE, START, DATA, PARITY, STOP; a 4-bit tick counter and a bit index of $clog2(DATA_BITS) bits shall advance only on sample_clk.
REQ-014 IDLE: on a tick with rx_s=0, go to START and clear the tick counter.
REQ-015 START: on the tick where counter=7 (mid-bit), if rx_s=0 go to DATA and clear the counter; if rx_s=1, treat as a glitch and return to IDLE without any output pulse.
REQ-016 DATA: on every tick where counter=15, shift rx_s into the word LSB-first and increment the bit index; after bit DATA_BITS-1, go to PARITY if PARITY_EN=1, else to STOP.
REQ-017 PARITY: sample on counter=15; compute mismatch = XOR(data bits, parity bit) XOR PARITY_ODD, then go to STOP.
REQ-018 STOP: sample on counter=15; if rx_s=1, load rx_data and pulse rx_valid (and parity_err if mismatch); if rx_s=0, pulse frame_err only and leave rx_data unchanged; return to IDLE in both cases.
REQ-019 Latency: each pulse shall assert in the sys_clk cycle after the cycle carrying the stop-sampling tick, and shall last exactly 1 cycle.
REQ-020 rx_data shall hold its value until the next good frame; there is no backpressure, and a new frame overwrites the word.
REQ-021 After frame_err, IDLE shall accept a new start only after rx_s has been sampled high on at least one tick (break handling).
REQ-022 The tick counter shall wrap 15->0; between ticks, all state shall hold.

Reset
REQ-023 On reset: state=IDLE, counters=0, rx_data=0, all pulses=0, synchronizer flops=1, break-armed flag=1.
REQ-024 Reset asserted mid-frame shall abort the frame with no pulse; the next start edge after deassertion shall be received normally.

Structure
REQ-025 State encodings and the oversample constant 16 shall live in the shared header uart_defs.vh, which the TX side also uses.
REQ-026 The 2-FF synchronizer shall be the single sub-module, uart_sync2; sample_clk is generated externally by the Rx clock generator block.

Verification
REQ-027 Drive sample_clk every 4 sys_clk; send 0xA5, 8N1 -> exactly one rx_valid, rx_data=0xA5, no error pulses.
REQ-028 Start low for 5 ticks, then high -> no pulse, FSM in IDLE; a following 0x3C frame is received correctly.
REQ-029 Send 0x55 with the stop bit held low, then the line low for 20 bit times -> one frame_err, rx_data unchanged, no further pulses until the line returns high; the next 0x81 is received correctly.
REQ-030 With PARITY_EN=1 and PARITY_ODD=0, send 0x07 with parity=0 -> rx_valid and parity_err together; with parity=1 -> rx_valid only.
REQ-031 Assert reset during bit 4 of a frame -> no pulse and all outputs at reset values; the subsequent 0xFF frame is received correctly.
REQ-032 Send back-to-back frames 0x00 and 0xFF with no idle gap -> two rx_valid pulses, 160 ticks apart.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART receive definitions: oversample ratio, tick compare points and FSM encoding.
package uart_rx_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam logic [3:0]  MID_TICK   = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]  LAST_TICK  = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB-first, optional parity, registered one-cycle result pulses.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic                 sample_clk,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic ODD_BIT = (PARITY_ODD != 0);
  localparam logic PAR_ON  = (PARITY_EN != 0);

  logic rx_s;

  uart_sync2 u_sync (
    .clk_i (sys_clk),
    .rst_i (reset),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  rx_state_e            state_q, state_d;
  logic [3:0]           tick_q, tick_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_q, par_d;
  logic                 mismatch_q, mismatch_d;
  logic                 armed_q, armed_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tick_q     <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      par_q      <= 1'b0;
      mismatch_q <= 1'b0;
      armed_q    <= 1'b1;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      par_q      <= par_d;
      mismatch_q <= mismatch_d;
      armed_q    <= armed_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    data_d     = data_q;
    par_d      = par_q;
    mismatch_d = mismatch_q;
    armed_d    = armed_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    perr_d     = 1'b0;

    if (sample_clk) begin
      tick_d = tick_q + 4'd1;
      unique case (state_q)
        ST_IDLE: begin
          tick_d = '0;
          // A stuck-low line after a framing error must go high before a new start counts.
          if (rx_s) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d = ST_START;
          end
        end
        ST_START: begin
          if (tick_q == MID_TICK) begin
            tick_d = '0;
            if (!rx_s) begin
              state_d    = ST_DATA;
              idx_d      = '0;
              par_d      = 1'b0;
              mismatch_d = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (tick_q == LAST_TICK) begin
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            par_d   = par_q ^ rx_s;
            if (idx_q == LAST_IDX) begin
              idx_d   = '0;
              state_d = PAR_ON ? ST_PARITY : ST_STOP;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (tick_q == LAST_TICK) begin
            mismatch_d = par_q ^ rx_s ^ ODD_BIT;
            state_d    = ST_STOP;
          end
        end
        ST_STOP: begin
          if (tick_q == LAST_TICK) begin
            state_d = ST_IDLE;
            tick_d  = '0;
            if (rx_s) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              perr_d  = mismatch_q & PAR_ON;
            end else begin
              ferr_d  = 1'b1;
              armed_d = 1'b0;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          tick_d  = '0;
        end
      endcase
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: an 8N1 instance and an 8E1 instance share clock, tick and reset.
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int BIT_CYC = 64;

  typedef struct {
    int         chan;
    logic       v;
    logic       f;
    logic       p;
    logic [7:0] d;
  } exp_t;

  logic       sys_clk = 1'b0;
  logic       reset = 1'b1;
  logic       sample_clk = 1'b0;
  logic [1:0] div = 2'd0;
  logic       rx0 = 1'b1;
  logic       rx1 = 1'b1;
  logic [7:0] data0, data1;
  logic       v0, f0, p0, v1, f1, p1;
  logic       v0_prev = 1'b0;
  logic       v1_prev = 1'b0;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  exp_t       sb[$];
  int         vcyc[$];

  uart_rx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .sys_clk(sys_clk), .reset(reset), .sample_clk(sample_clk), .rx(rx0),
    .rx_data(data0), .rx_valid(v0), .frame_err(f0), .parity_err(p0)
  );

  uart_rx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .sys_clk(sys_clk), .reset(reset), .sample_clk(sample_clk), .rx(rx1),
    .rx_data(data1), .rx_valid(v1), .frame_err(f1), .parity_err(p1)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    cyc <= cyc + 1;
    div <= div + 2'd1;
    sample_clk <= (div == 2'd3);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_pulse(input int chan, input logic v, input logic f, input logic p,
                             input logic [7:0] d);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_pulse: chan %0d got v=%0b f=%0b p=%0b d=0x%0h expected none",
               chan, v, f, p, d);
    end else begin
      e = sb.pop_front();
      if (e.chan != chan || e.v !== v || e.f !== f || e.p !== p || e.d !== d) begin
        n_fail++;
        $display("FAIL pulse: got chan %0d v=%0b f=%0b p=%0b d=0x%0h expected chan %0d v=%0b f=%0b p=%0b d=0x%0h",
                 chan, v, f, p, d, e.chan, e.v, e.f, e.p, e.d);
      end
    end
  endtask

  always @(negedge sys_clk) begin
    if (!reset) begin
      if (v0 || f0 || p0) check_pulse(0, v0, f0, p0, data0);
      if (v1 || f1 || p1) check_pulse(1, v1, f1, p1, data1);
      if (v0) begin
        vcyc.push_back(cyc);
        chk("valid0_width", {31'd0, v0_prev}, 32'd0);
      end
      if (v1) chk("valid1_width", {31'd0, v1_prev}, 32'd0);
    end
    v0_prev <= v0;
    v1_prev <= v1;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic drive_bit(input int chan, input logic val);
    if (chan == 0) rx0 = val;
    else rx1 = val;
    wait_cycles(BIT_CYC);
  endtask

  task automatic send_frame(input int chan, input logic [7:0] d, input logic par_en,
                            input logic par_bit, input logic stop_bit);
    drive_bit(chan, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(chan, d[i]);
    if (par_en) drive_bit(chan, par_bit);
    drive_bit(chan, stop_bit);
  endtask

  task automatic expect_pulse(input int chan, input logic v, input logic f, input logic p,
                              input logic [7:0] d);
    exp_t e;
    e.chan = chan; e.v = v; e.f = f; e.p = p; e.d = d;
    sb.push_back(e);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] partial;
    wait_cycles(8);
    chk("reset_outputs0", {20'd0, data0, v0, f0, p0, 1'b0}, 32'd0);
    chk("reset_outputs1", {20'd0, data1, v1, f1, p1, 1'b0}, 32'd0);
    reset = 1'b0;
    wait_cycles(BIT_CYC);

    expect_pulse(0, 1'b1, 1'b0, 1'b0, 8'hA5);
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    wait_cycles(BIT_CYC);

    rx0 = 1'b0;
    wait_cycles(20);
    rx0 = 1'b1;
    wait_cycles(2 * BIT_CYC);
    chk("glitch_idle", {29'd0, dut.state_q}, {29'd0, ST_IDLE});
    expect_pulse(0, 1'b1, 1'b0, 1'b0, 8'h3C);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    wait_cycles(BIT_CYC);

    expect_pulse(0, 1'b0, 1'b1, 1'b0, 8'h3C);
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
    wait_cycles(20 * BIT_CYC);
    chk("break_hold_data", {24'd0, data0}, 32'h3C);
    rx0 = 1'b1;
    wait_cycles(2 * BIT_CYC);
    expect_pulse(0, 1'b1, 1'b0, 1'b0, 8'h81);
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
    wait_cycles(BIT_CYC);

    expect_pulse(1, 1'b1, 1'b0, 1'b1, 8'h07);
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
    wait_cycles(BIT_CYC);
    expect_pulse(1, 1'b1, 1'b0, 1'b0, 8'h07);
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
    wait_cycles(BIT_CYC);

    partial = 8'h5A;
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, partial[i]);
    rx0 = partial[4];
    wait_cycles(BIT_CYC / 2);
    reset = 1'b1;
    wait_cycles(3);
    chk("midframe_reset0", {20'd0, data0, v0, f0, p0, 1'b0}, 32'd0);
    chk("midframe_reset1", {20'd0, data1, v1, f1, p1, 1'b0}, 32'd0);
    rx0 = 1'b1;
    reset = 1'b0;
    wait_cycles(2 * BIT_CYC);
    expect_pulse(0, 1'b1, 1'b0, 1'b0, 8'hFF);
    send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1);
    wait_cycles(BIT_CYC);

    vcyc.delete();
    expect_pulse(0, 1'b1, 1'b0, 1'b0, 8'h00);
    expect_pulse(0, 1'b1, 1'b0, 1'b0, 8'hFF);
    send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1);
    wait_cycles(2 * BIT_CYC);
    chk("b2b_count", vcyc.size(), 32'd2);
    if (vcyc.size() == 2) chk("b2b_gap", vcyc[1] - vcyc[0], 32'(10 * BIT_CYC));

    for (int i = 0; i < 2000 && sb.size() != 0; i++) wait_cycles(1);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
